// File: rtl/axis_mux_top.sv
// axis_mux_top: two free-running packet generators feeding a packet-aware
// 2:1 mux that drives one registered AXI4-Stream master port. The source
// is chosen only at packet start, so every output packet comes from a
// single generator.
//
// state | meaning
// ------+---------------------------------------------------------------
// SRC0  | generator 0 owns the current packet (also the reset state)
// SRC1  | generator 1 owns the current packet
module axis_mux_top #(
  parameter int          DATA_WIDTH = 32,
  parameter int          PKT_LEN    = 16,
  parameter logic [31:0] SRC0_BASE  = 32'h0000_0000,
  parameter logic [31:0] SRC1_BASE  = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  // A one-beat packet still needs a 1-bit counter to keep the vectors legal.
  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  localparam logic [0:0] SRC0 = 1'b0;
  localparam logic [0:0] SRC1 = 1'b1;

  localparam logic [DATA_WIDTH-1:0] BASE0 = DATA_WIDTH'(SRC0_BASE);
  localparam logic [DATA_WIDTH-1:0] BASE1 = DATA_WIDTH'(SRC1_BASE);

  logic [0:0]            state;
  logic [0:0]            state_next;
  logic [0:0]            src_now;
  logic                  load;
  logic                  pkt_start;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [BEAT_W-1:0]     beat_next;
  logic [DATA_WIDTH-1:0] w0;
  logic [DATA_WIDTH-1:0] w1;
  logic [DATA_WIDTH-1:0] word_now;

  // Output register accepts a new beat when empty or when downstream takes the current one.
  always_comb begin
    load      = !m_axis_tvalid || m_axis_tready;
    pkt_start = (beat_cnt == '0);
  end

  // sel applies to the very beat loaded at packet start, so resolve the source combinationally.
  always_comb begin
    src_now    = state;
    state_next = state;
    if (pkt_start) begin
      src_now = sel ? SRC1 : SRC0;
    end
    if (load && pkt_start) begin
      state_next = src_now;
    end
  end

  // Next data word of the source that owns this beat; wraps modulo 2^DATA_WIDTH.
  always_comb begin
    word_now = (src_now == SRC1) ? (BASE1 + w1) : (BASE0 + w0);
  end

  // Beat counter wraps after the tlast beat.
  always_comb begin
    beat_next = (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
  end

  // Source FSM state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SRC0;
    end else begin
      state <= state_next;
    end
  end

  // Packet beat counter advances on every loaded beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt <= '0;
    end else if (load) begin
      beat_cnt <= beat_next;
    end
  end

  // Generator 0 word counter; holds while generator 1 is being drained.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w0 <= '0;
    end else if (load && (src_now == SRC0)) begin
      w0 <= w0 + 1'b1;
    end
  end

  // Generator 1 word counter; holds while generator 0 is being drained.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w1 <= '0;
    end else if (load && (src_now == SRC1)) begin
      w1 <= w1 + 1'b1;
    end
  end

  // Registered AXI4-Stream output; held stable while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (load) begin
      m_axis_tdata  <= word_now;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= (beat_cnt == LAST_BEAT);
    end
  end

endmodule

// File: tb/tb_axis_mux_top.sv
// Directed bench for axis_mux_top: a 16-beat instance covers normal
// streaming, source switching, back-pressure and mid-packet reset; a
// 1-beat instance covers per-beat source selection.
module tb_axis_mux_top;

  logic        clk;
  logic        reset;
  logic        sel;
  logic        tready;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;

  logic        reset1;
  logic        sel1;
  logic        tready1;
  logic [31:0] tdata1;
  logic        tvalid1;
  logic        tlast1;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int idx;
  logic [63:0] pat;

  axis_mux_top #(.DATA_WIDTH(32), .PKT_LEN(16)) dut16 (
    .clk(clk), .reset(reset), .sel(sel),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tlast(tlast)
  );

  axis_mux_top #(.DATA_WIDTH(32), .PKT_LEN(1)) dut1 (
    .clk(clk), .reset(reset1), .sel(sel1),
    .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1),
    .m_axis_tready(tready1), .m_axis_tlast(tlast1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the beat on display at this negedge, then move to the next negedge.
  task automatic expect_beat(input string tag, input logic [31:0] d, input logic l);
    chk({tag, " tvalid"}, 64'(tvalid), 64'd1);
    chk({tag, " tdata"}, 64'(tdata), 64'(d));
    chk({tag, " tlast"}, 64'(tlast), 64'(l));
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge showing beat 0.
  task automatic reset_seq(input logic s);
    reset = 1'b0;
    sel   = s;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset   = 1'b0;
    sel     = 1'b0;
    tready  = 1'b1;
    reset1  = 1'b0;
    sel1    = 1'b0;
    tready1 = 1'b1;
    pat     = 64'hA5C3_1E77_0F96_D24B;

    // Reset values
    @(negedge clk);
    chk("rst tvalid", 64'(tvalid), 64'd0);
    chk("rst tdata", 64'(tdata), 64'd0);
    chk("rst tlast", 64'(tlast), 64'd0);
    chk("rst1 tvalid", 64'(tvalid1), 64'd0);

    // Generator 0, two back-to-back packets
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      expect_beat("t1", 32'(i), (i % 16) == 15);
    end

    // Generator 1 from reset
    reset_seq(1'b1);
    for (int i = 0; i < 16; i++) begin
      expect_beat("t2", 32'h8000_0000 + 32'(i), i == 15);
    end

    // sel change mid-packet takes effect only at the next packet
    reset_seq(1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) sel = 1'b1;
      expect_beat("t3 p1", 32'(i), i == 15);
    end
    for (int i = 0; i < 16; i++) begin
      if (i == 2) sel = 1'b0;
      expect_beat("t3 p2", 32'h8000_0000 + 32'(i), i == 15);
    end
    for (int i = 0; i < 4; i++) begin
      expect_beat("t3 p3", 32'h10 + 32'(i), 1'b0);
    end

    // Back-pressure: first beat loads into the empty register despite tready=0
    reset  = 1'b0;
    sel    = 1'b0;
    tready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    idx = 0;
    for (int c = 0; c < 80; c++) begin
      chk("t4 tvalid", 64'(tvalid), 64'd1);
      chk("t4 tdata", 64'(tdata), 64'(idx));
      chk("t4 tlast", 64'(tlast), 64'((idx % 16) == 15));
      tready = pat[c % 64];
      @(negedge clk);
      if (tready) idx++;
    end
    chk("t4 accepted", 64'(idx > 16), 64'd1);
    tready = 1'b1;

    // Asynchronous reset mid-packet
    reset_seq(1'b1);
    for (int i = 0; i < 7; i++) begin
      expect_beat("t5 pre", 32'h8000_0000 + 32'(i), 1'b0);
    end
    chk("t5 beat7", 64'(tdata), 64'h8000_0007);
    #2 reset = 1'b0;
    #1;
    chk("t5 async tvalid", 64'(tvalid), 64'd0);
    chk("t5 async tdata", 64'(tdata), 64'd0);
    chk("t5 async tlast", 64'(tlast), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (i == 3) sel = 1'b0;
      expect_beat("t5 post", 32'h8000_0000 + 32'(i), i == 15);
    end
    for (int i = 0; i < 2; i++) begin
      expect_beat("t5 src0", 32'(i), 1'b0);
    end

    // One-beat packets, sel alternating every beat
    sel1 = 1'b0;
    @(negedge clk);
    reset1 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk("t6 tvalid", 64'(tvalid1), 64'd1);
      chk("t6 tlast", 64'(tlast1), 64'd1);
      chk("t6 tdata", 64'(tdata1),
          64'(((i % 2) == 1) ? (32'h8000_0000 + 32'(i / 2)) : 32'(i / 2)));
      sel1 = ((i + 1) % 2) == 1;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
